// File: rtl/ring_mon_pkg.sv
// ----------------------------------------------------------------------------
// ring_mon_pkg
// Shared types for the ring phase monitor: the monitor FSM state encoding and
// the fault classification codes reported on err_code.
// ----------------------------------------------------------------------------
package ring_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_CHECK = 3'd2,
        ST_TRACK = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Ordered by reporting priority: zero-hot beats multi-hot beats skip.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ZERO  = 2'd1,
        ERR_MULTI = 2'd2,
        ERR_SKIP  = 2'd3
    } err_code_e;

endpackage

// File: rtl/ring_phase_monitor_if.sv
// ----------------------------------------------------------------------------
// ring_phase_monitor_if
// Bundles the ring-side and status signals of the ring phase monitor.
//   ring_q      : one-hot phase vector from the ring counter
//   enable      : ring advances one phase per clk while high
//   clear_err   : clears the latched fault and returns the monitor to idle
//   start_req   : one-cycle restart pulse for the ring counter start input
//   phase_idx   : binary index of the active phase
//   phase_valid : phase_idx is meaningful
//   wrap        : one-cycle pulse on a phase N-1 -> 0 transition
//   rev_count   : completed revolutions since the last arm
//   err         : sticky fault flag
//   err_code    : fault classification (see ring_mon_pkg::err_code_e)
// master = the monitor, slave = the ring counter / system side.
// ----------------------------------------------------------------------------
interface ring_phase_monitor_if #(
    parameter int N     = 4,
    parameter int REV_W = 8
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     ring_q;
    logic             enable;
    logic             clear_err;
    logic             start_req;
    logic [IDX_W-1:0] phase_idx;
    logic             phase_valid;
    logic             wrap;
    logic [REV_W-1:0] rev_count;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        input  ring_q, enable, clear_err,
        output start_req, phase_idx, phase_valid, wrap, rev_count, err, err_code
    );

    modport slave (
        output ring_q, enable, clear_err,
        input  start_req, phase_idx, phase_valid, wrap, rev_count, err, err_code
    );
endinterface

// File: rtl/onehot_check.sv
// ----------------------------------------------------------------------------
// onehot_check
// Purely combinational decode of a phase vector.
//   vec_i   : phase vector under test
//   zero_o  : no bit set
//   multi_o : more than one bit set
//   index_o : position of the set bit (meaningful only when one-hot)
// ----------------------------------------------------------------------------
module onehot_check #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic             zero_o,
    output logic             multi_o,
    output logic [IDX_W-1:0] index_o
);
    assign zero_o  = ~|vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - N'(1)));

    always_comb begin
        index_o = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) index_o = IDX_W'(i);
        end
    end
endmodule

// File: rtl/ring_phase_monitor.sv
// ----------------------------------------------------------------------------
// ring_phase_monitor
// Watches a one-hot ring counter, restarts it, tracks its phase and counts
// revolutions, and classifies and latches any corruption of the ring.
//   clk : sole clock, all state on the rising edge
//   rst : synchronous active-high reset, dominates every other input
//   bus : ring_phase_monitor_if.master (ring inputs and all status outputs)
// Every output comes straight from a register.
// ----------------------------------------------------------------------------
module ring_phase_monitor #(
    parameter int N         = 4,
    parameter int REV_W     = 8,
    parameter int RETRY_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    ring_phase_monitor_if.master bus
);
    import ring_mon_pkg::*;

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int RC_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_e           state_q, state_d;
    logic             start_req_q, start_req_d;
    logic             phase_valid_q, phase_valid_d;
    logic             wrap_q, wrap_d;
    logic [IDX_W-1:0] phase_idx_q, phase_idx_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             err_q, err_d;
    err_code_e        err_code_q, err_code_d;
    logic [RC_W-1:0]  retry_cnt_q, retry_cnt_d;

    // Previous ring sample and the enable seen alongside it. The ring moves on
    // the same edge that samples enable, so the step between two samples is
    // governed by the enable that accompanied the older one.
    logic [N-1:0]     prev_q;
    logic             en_q;

    logic             vec_zero, vec_multi;
    logic [IDX_W-1:0] vec_index;
    logic [N-1:0]     expect_vec;
    err_code_e        obs_code;
    logic             fault_det;

    onehot_check #(.N(N), .IDX_W(IDX_W)) u_onehot_check (
        .vec_i   (bus.ring_q),
        .zero_o  (vec_zero),
        .multi_o (vec_multi),
        .index_o (vec_index)
    );

    // Classify the current sample against what the ring should show now.
    always_comb begin
        if (state_q == ST_CHECK) expect_vec = N'(1);
        else if (en_q)           expect_vec = {prev_q[N-2:0], prev_q[N-1]};
        else                     expect_vec = prev_q;

        if (vec_zero)                      obs_code = ERR_ZERO;
        else if (vec_multi)                obs_code = ERR_MULTI;
        else if (bus.ring_q != expect_vec) obs_code = ERR_SKIP;
        else                               obs_code = ERR_NONE;

        fault_det = ((state_q == ST_CHECK) || (state_q == ST_TRACK)) &&
                    (obs_code != ERR_NONE);
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        state_d       = state_q;
        phase_valid_d = 1'b0;
        wrap_d        = 1'b0;
        phase_idx_d   = phase_idx_q;
        rev_count_d   = rev_count_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        retry_cnt_d   = retry_cnt_q;

        if (fault_det) begin
            // A fault seen in the same cycle as clear_err still wins.
            state_d    = ST_FAULT;
            err_d      = 1'b1;
            err_code_d = obs_code;
        end else if (bus.clear_err) begin
            state_d    = ST_IDLE;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (bus.enable) state_d = ST_ARM;
                ST_ARM:   state_d = ST_CHECK;
                ST_CHECK: begin
                    state_d       = ST_TRACK;
                    rev_count_d   = '0;
                    phase_valid_d = 1'b1;
                    phase_idx_d   = vec_index;
                end
                ST_TRACK: begin
                    phase_valid_d = 1'b1;
                    phase_idx_d   = vec_index;
                    // A legal advance out of the top phase is a completed revolution.
                    if (en_q && prev_q[N-1]) begin
                        wrap_d      = 1'b1;
                        rev_count_d = rev_count_q + REV_W'(1);
                        retry_cnt_d = '0;
                    end
                end
                ST_FAULT: begin
                    if (retry_cnt_q < RC_W'(RETRY_MAX)) begin
                        state_d     = ST_ARM;
                        retry_cnt_d = retry_cnt_q + RC_W'(1);
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end

        if (bus.clear_err) retry_cnt_d = '0;

        // The restart pulse is exactly the single cycle spent in ARM.
        start_req_d = (state_d == ST_ARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_req_q   <= 1'b0;
            phase_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
            phase_idx_q   <= '0;
            rev_count_q   <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            retry_cnt_q   <= '0;
            prev_q        <= '0;
            en_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q       <= state_d;
            start_req_q   <= start_req_d;
            phase_valid_q <= phase_valid_d;
            wrap_q        <= wrap_d;
            phase_idx_q   <= phase_idx_d;
            rev_count_q   <= rev_count_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            retry_cnt_q   <= retry_cnt_d;
            prev_q        <= bus.ring_q;
            en_q          <= bus.enable;
        end
    end

    assign bus.start_req   = start_req_q;
    assign bus.phase_idx   = phase_idx_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.wrap        = wrap_q;
    assign bus.rev_count   = rev_count_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// ----------------------------------------------------------------------------
// tb_ring_phase_monitor
// Drives ring_phase_monitor with a behavioural ring counter (restarted by the
// expected start_req pulse), directed fault injection and a randomized soak,
// and compares every output each cycle against a reference model.
// ----------------------------------------------------------------------------
module tb_ring_phase_monitor;
    localparam int N         = 4;
    localparam int REV_W     = 8;
    localparam int RETRY_MAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ring_phase_monitor_if #(.N(N), .REV_W(REV_W)) bus ();

    ring_phase_monitor #(.N(N), .REV_W(REV_W), .RETRY_MAX(RETRY_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ARM, M_CHECK, M_TRACK, M_FAULT} mode_t;
    mode_t        m_mode    = M_IDLE;
    logic [N-1:0] m_prev    = '0;
    bit           m_prev_en = 1'b0;
    int           m_retry   = 0;
    int           m_rev     = 0;
    bit           e_start = 0, e_valid = 0, e_wrap = 0, e_err = 0;
    int           e_code = 0, e_idx = 0;

    function automatic int pos_of(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return 0;
    endfunction

    // 0 ok, 1 zero-hot, 2 multi-hot, 3 one-hot in the wrong place.
    function automatic int classify(input logic [N-1:0] r, input int want);
        int c = $countones(r);
        if (c == 0) return 1;
        if (c > 1) return 2;
        if (pos_of(r) != want) return 3;
        return 0;
    endfunction

    task automatic model_step(input bit r, input bit clr, input bit en, input logic [N-1:0] ring);
        int  want, code;
        bit  fault;
        if (r) begin
            m_mode = M_IDLE; m_retry = 0; m_rev = 0; m_prev = '0; m_prev_en = 0;
            e_start = 0; e_valid = 0; e_wrap = 0; e_err = 0; e_code = 0; e_idx = 0;
            return;
        end
        want  = (m_mode == M_CHECK) ? 0 : (pos_of(m_prev) + (m_prev_en ? 1 : 0)) % N;
        code  = classify(ring, want);
        fault = (m_mode == M_CHECK || m_mode == M_TRACK) && code != 0;
        e_valid = 0;
        e_wrap  = 0;
        if (fault) begin
            m_mode = M_FAULT; e_err = 1; e_code = code;
        end else if (clr) begin
            m_mode = M_IDLE; e_err = 0; e_code = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (en) m_mode = M_ARM;
                M_ARM:   m_mode = M_CHECK;
                M_CHECK: begin m_mode = M_TRACK; m_rev = 0; e_valid = 1; e_idx = 0; end
                M_TRACK: begin
                    e_valid = 1;
                    e_idx   = pos_of(ring);
                    if (m_prev_en && pos_of(m_prev) == N - 1) begin
                        e_wrap = 1; m_rev = (m_rev + 1) % (1 << REV_W); m_retry = 0;
                    end
                end
                M_FAULT: if (m_retry < RETRY_MAX) begin m_retry++; m_mode = M_ARM; end
            endcase
        end
        if (clr) m_retry = 0;
        e_start   = (m_mode == M_ARM);
        m_prev    = ring;
        m_prev_en = en;
    endtask

    // ---------------- environment ----------------
    logic [N-1:0] env_ring = '0;
    bit           ovr_en   = 0;
    logic [N-1:0] ovr_val  = '0;
    int           n_wrap   = 0;
    int           n_start  = 0;

    task automatic apply_ring();
        bus.ring_q = ovr_en ? ovr_val : env_ring;
    endtask

    task automatic set_ovr(input bit en, input logic [N-1:0] val);
        ovr_en  = en;
        ovr_val = val;
        apply_ring();
    endtask

    task automatic cycle();
        bit prev_start;
        @(posedge clk);
        prev_start = e_start;
        model_step(rst, bus.clear_err, bus.enable, bus.ring_q);
        if (rst)                env_ring = '0;
        else if (prev_start)    env_ring = N'(1);
        else if (bus.enable)    env_ring = {env_ring[N-2:0], env_ring[N-1]};
        #1;
        check("start_req",   32'(bus.start_req),   32'(e_start));
        check("phase_valid", 32'(bus.phase_valid), 32'(e_valid));
        check("wrap",        32'(bus.wrap),        32'(e_wrap));
        check("rev_count",   32'(bus.rev_count),   m_rev);
        check("err",         32'(bus.err),         32'(e_err));
        check("err_code",    32'(bus.err_code),    e_code);
        if (e_valid) check("phase_idx", 32'(bus.phase_idx), e_idx);
        if (bus.wrap === 1'b1)      n_wrap++;
        if (bus.start_req === 1'b1) n_start++;
        apply_ring();
    endtask

    int idx0;

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.clear_err = 1'b0;
        bus.ring_q = '0;

        // Reset state.
        repeat (3) cycle();
        check("rst_idx", 32'(bus.phase_idx), 0);
        check("rst_valid", 32'(bus.phase_valid), 0);

        // Bring-up: restart pulse, then phases 0,1,2,3,0.
        rst = 1'b0;
        bus.enable = 1'b1;
        cycle(); check("arm_pulse", 32'(bus.start_req), 1);
        cycle(); check("arm_one_cycle", 32'(bus.start_req), 0);
        cycle(); check("first_valid", 32'(bus.phase_valid), 1);
        check("first_idx", 32'(bus.phase_idx), 0);

        // 256 revolutions: one wrap each, counter rolls back to zero.
        n_wrap = 0;
        for (int k = 1; k <= 256 * N; k++) begin
            cycle();
            if (k <= N) check("seq_idx", 32'(bus.phase_idx), k % N);
            if (k == N) check("seq_wrap", 32'(bus.wrap), 1);
        end
        check("wraps_256", n_wrap, 256);
        check("rev_rollover", 32'(bus.rev_count), 0);
        check("no_err_run", 32'(bus.err), 0);

        // Enable low for 5 cycles with ring held.
        bus.enable = 1'b0;
        n_wrap = 0;
        cycle();
        idx0 = e_idx;
        repeat (4) cycle();
        check("hold_idx", 32'(bus.phase_idx), idx0);
        check("hold_no_wrap", n_wrap, 0);
        check("hold_no_err", 32'(bus.err), 0);
        bus.enable = 1'b1;

        // Random enable pattern while tracking.
        repeat (200) begin
            bus.enable = ($urandom_range(0, 99) < 70);
            cycle();
        end
        bus.enable = 1'b1;
        repeat (2) cycle();

        // Zero-hot in TRACK, then recovery with err sticky.
        set_ovr(1, '0);
        cycle();
        check("zero_code", 32'(bus.err_code), 1);
        check("zero_valid", 32'(bus.phase_valid), 0);
        set_ovr(0, '0);
        repeat (8) cycle();
        check("sticky_err", 32'(bus.err), 1);
        check("sticky_code", 32'(bus.err_code), 1);
        check("recovered", 32'(bus.phase_valid), 1);
        bus.clear_err = 1'b1; cycle(); bus.clear_err = 1'b0;
        repeat (8) cycle();

        // Multi-hot.
        set_ovr(1, N'(6));
        cycle();
        check("multi_code", 32'(bus.err_code), 2);
        set_ovr(0, '0);
        repeat (8) cycle();
        bus.clear_err = 1'b1; cycle(); bus.clear_err = 1'b0;
        repeat (8) cycle();

        // Skip: 0001 followed by 0100.
        for (int t = 0; t < 2 * N && bus.ring_q != N'(1); t++) cycle();
        check("skip_sync", 32'(bus.ring_q == N'(1)), 1);
        cycle();
        set_ovr(1, N'(4));
        cycle();
        check("skip_code", 32'(bus.err_code), 3);
        check("skip_err", 32'(bus.err), 1);
        set_ovr(0, '0);
        repeat (8) cycle();
        bus.clear_err = 1'b1; cycle(); bus.clear_err = 1'b0;
        repeat (8) cycle();

        // Persistent fault: exactly RETRY_MAX restarts, then held.
        set_ovr(1, '0);
        n_start = 0;
        repeat (40) cycle();
        check("retry_pulses", n_start, RETRY_MAX);
        check("retry_err", 32'(bus.err), 1);
        n_start = 0;
        repeat (10) cycle();
        check("no_more_start", n_start, 0);

        // clear_err out of the held fault.
        set_ovr(0, '0);
        bus.clear_err = 1'b1; cycle(); bus.clear_err = 1'b0;
        check("clear_from_fault", 32'(bus.err), 0);
        repeat (6) cycle();

        // clear_err together with a zero-hot fault: the fault wins.
        set_ovr(1, '0);
        bus.clear_err = 1'b1;
        cycle();
        bus.clear_err = 1'b0;
        set_ovr(0, '0);
        check("clr_vs_fault_err", 32'(bus.err), 1);
        check("clr_vs_fault_code", 32'(bus.err_code), 1);
        repeat (10) cycle();
        bus.clear_err = 1'b1; cycle(); bus.clear_err = 1'b0;
        check("clean_clear_err", 32'(bus.err), 0);
        check("clean_clear_code", 32'(bus.err_code), 0);
        check("clean_clear_valid", 32'(bus.phase_valid), 0);
        repeat (6) cycle();

        // Reset dominates clear_err and a fault.
        rst = 1'b1; bus.clear_err = 1'b1; set_ovr(1, N'(6));
        cycle();
        check("rst_mid_err", 32'(bus.err), 0);
        check("rst_mid_rev", 32'(bus.rev_count), 0);
        rst = 1'b0; bus.clear_err = 1'b0; set_ovr(0, '0);

        // Randomized soak.
        repeat (1500) begin
            bus.enable    = ($urandom_range(0, 99) < 85);
            bus.clear_err = ($urandom_range(0, 99) < 3);
            rst           = ($urandom_range(0, 999) < 5);
            if ($urandom_range(0, 99) < 3) set_ovr(1, N'($urandom));
            else                           set_ovr(0, '0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 Parameter N, default 4, ring width in phases (N >= 2).
REQ-002 Parameter REV_W, default 8, width of revolution counter.
REQ-003 Parameter RETRY_MAX, default 3, automatic re-arm attempts before fault latches.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ring_q  in  N  one-hot phase vector from the ring counter.
REQ-007 enable  in  1  high = ring advances one phase per clk.
REQ-008 clear_err  in  1  clears latched fault, returns to IDLE.
REQ-009 start_req  out  1  one-cycle restart pulse driving the ring counter start input.
REQ-010 phase_idx  out  clog2(N)  binary index of the active phase.
REQ-011 phase_valid  out  1  phase_idx meaningful (TRACK, no fault this cycle).
REQ-012 wrap  out  1  one-cycle pulse on phase N-1 -> 0 transition.
REQ-013 rev_count  out  REV_W  completed revolutions since last arm.
REQ-014 err  out  1  sticky fault flag.
REQ-015 err_code  out  2  0 none, 1 zero-hot, 2 multi-hot, 3 skip.

Function
REQ-016 FSM states IDLE, ARM, CHECK, TRACK, FAULT; all outputs registered.
REQ-017 IDLE: enable=1 -> ARM; else stay.
REQ-018 ARM: start_req=1 for exactly that one cycle; next state CHECK.
REQ-019 CHECK: ring_q == 1 (bit 0 only) -> TRACK, rev_count cleared; otherwise -> FAULT with classified code.
REQ-020 TRACK, enable=1: ring_q shall equal rotate-left-by-1 of previous sample; enable=0: ring_q shall equal previous sample.
REQ-021 Fault classification priority: zero-hot > multi-hot > skip (one-hot but wrong position).
REQ-022 Any TRACK violation -> FAULT next cycle; err=1, err_code set, phase_valid=0.
REQ-023 phase_idx/phase_valid latency: one clk after ring_q sampled.
REQ-024 wrap=1 one clk after sampling phase 0 preceded by phase N-1; rev_count increments same cycle, wraps 2^REV_W-1 -> 0.
REQ-025 FAULT: retry_cnt < RETRY_MAX -> ARM next cycle, retry_cnt+1; else remain until clear_err.
REQ-026 err/err_code stay latched across retries; only clear_err or rst clears them.
REQ-027 retry_cnt cleared on first wrap in TRACK.
REQ-028 clear_err in any state -> IDLE, clears err, err_code, retry_cnt; fault detected same cycle wins (FAULT, new code).
REQ-029 enable falling in TRACK: stay TRACK, hold checks; in ARM/CHECK ignored.

Reset
REQ-030 rst=1 at clk edge: state IDLE, start_req 0, phase_idx 0, phase_valid 0, wrap 0, rev_count 0, err 0, err_code 0, retry_cnt 0.
REQ-031 rst mid-operation dominates all inputs, including clear_err and faults.

Structure
REQ-032 Package ring_mon_pkg holds the state enum and err_code enum/constants.
REQ-033 One combinational sub-module onehot_check: ring_q -> zero, multi, index.
REQ-034 No latches; no asynchronous paths; single always_ff for state.

Verification (N=4)
REQ-035 rst, enable=1, model ring from start_req -> start_req pulse cycle 2, phase_valid by cycle 4, phase_idx 0,1,2,3,0.
REQ-036 Run 256 revolutions -> 256 wrap pulses, rev_count wraps to 0, err=0.
REQ-037 In TRACK force ring_q=0000 -> err_code=1; 0110 -> 2; 0001->0100 -> 3; err sticky.
REQ-038 Persistent fault -> exactly 3 start_req retries, then FAULT held, no further start_req.
REQ-039 clear_err with simultaneous zero-hot fault -> FAULT, err_code=1; clean clear_err -> IDLE, err=0.
REQ-040 enable=0 for 5 cycles in TRACK with ring held -> no fault, phase_idx constant, no wrap.
